udp_pkt_fifo: RTL and testbench

Parametrised single-clock packet FIFO for the UDP transmit/receive datapath. It buffers variable-length frames word by word. Frames become visible to the reader only after their last word is committed, and a frame can be discarded mid-write. A per-word `last` marker and a committed-packet count let downstream framers stream whole packets without re-deriving boundaries. It supersedes the fixed 8-bit/2K-deep soft FIFO. It adds width/depth generics, show-ahead mode, commit/rollback and packet accounting.

---
 rtl/udp_pkt_fifo.sv | 149 ++++++++++++++
 tb/tb_udp_pkt_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_fifo.sv
// Single-clock packet FIFO with speculative write pointer, commit/rollback of
// frames, per-word last marker and committed-packet accounting.
module udp_pkt_fifo #(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    ADDR_WIDTH    = 11,
    parameter int                    SHOW_AHEAD_EN = 0,
    parameter int                    AL_FULL_NUM   = 3,
    parameter int                    AL_EMPTY_NUM  = 2,
    parameter logic [DATA_WIDTH-1:0] DOUT_INITVAL  = '0
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  wlast,
    input  logic                  wdrop,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_last,
    output logic                  valid,
    output logic                  empty_flag,
    output logic                  aempty,
    output logic                  full_flag,
    output logic                  afull,
    output logic                  wr_success,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  drop_done,
    output logic [ADDR_WIDTH:0]   rdusedw,
    output logic [ADDR_WIDTH:0]   wrusedw,
    output logic [ADDR_WIDTH:0]   pkt_cnt
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_W    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_TH = DEPTH_W - (ADDR_WIDTH+1)'(AL_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AEMPTY_TH = (ADDR_WIDTH+1)'(AL_EMPTY_NUM);

    logic [DATA_WIDTH:0]  mem [DEPTH];
    // Copy of the last bits, read combinationally for packet accounting so the
    // main array keeps a purely registered read port in mode 0.
    logic                 last_mem [DEPTH];

    logic [ADDR_WIDTH:0]  wp_reg, cp_reg, rp_reg, pkt_cnt_reg;
    logic                 err_reg;
    logic                 wr_success_reg, overflow_reg, underflow_reg, drop_done_reg;

    logic wr_ok, rd_ok, commit, rollback, ovf, pop_last;

    assign wrusedw    = wp_reg - rp_reg;
    assign rdusedw    = cp_reg - rp_reg;
    assign full_flag  = (wrusedw == DEPTH_W);
    assign empty_flag = (rdusedw == '0);
    assign afull      = (wrusedw >= AFULL_TH);
    assign aempty     = (rdusedw <= AEMPTY_TH);
    assign pkt_cnt    = pkt_cnt_reg;

    assign wr_success = wr_success_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;
    assign drop_done  = drop_done_reg;

    assign wr_ok    = we && !full_flag && !wdrop;
    assign rd_ok    = re && !empty_flag;
    assign ovf      = we && full_flag && !wdrop;
    // A frame that has lost a word is rolled back when its last word arrives.
    assign rollback = wdrop || (we && wlast && (full_flag || err_reg));
    assign commit   = wr_ok && wlast && !err_reg;
    assign pop_last = rd_ok && last_mem[rp_reg[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp_reg[ADDR_WIDTH-1:0]]      <= {wlast, di};
            last_mem[wp_reg[ADDR_WIDTH-1:0]] <= wlast;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wp_reg         <= '0;
            cp_reg         <= '0;
            rp_reg         <= '0;
            pkt_cnt_reg    <= '0;
            err_reg        <= 1'b0;
            wr_success_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            drop_done_reg  <= 1'b0;
        end else begin
            if (rollback)
                wp_reg <= cp_reg;
            else if (wr_ok)
                wp_reg <= wp_reg + ONE_W;

            if (commit)
                cp_reg <= wp_reg + ONE_W;

            if (rd_ok)
                rp_reg <= rp_reg + ONE_W;

            if (commit && !pop_last)
                pkt_cnt_reg <= pkt_cnt_reg + ONE_W;
            else if (pop_last && !commit)
                pkt_cnt_reg <= pkt_cnt_reg - ONE_W;

            if (rollback)
                err_reg <= 1'b0;
            else if (ovf)
                err_reg <= 1'b1;

            wr_success_reg <= commit;
            overflow_reg   <= ovf;
            underflow_reg  <= re && empty_flag;
            drop_done_reg  <= rollback;
        end
    end

    generate
        if (SHOW_AHEAD_EN != 0) begin : g_show_ahead
            logic [DATA_WIDTH:0] head_word;
            assign head_word = mem[rp_reg[ADDR_WIDTH-1:0]];
            assign valid     = !empty_flag;
            assign dout      = valid ? head_word[DATA_WIDTH-1:0] : DOUT_INITVAL;
            assign dout_last = valid && head_word[DATA_WIDTH];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] dout_reg;
            logic                  dout_last_reg;
            logic                  valid_reg;

            always_ff @(posedge clk or posedge srst) begin
                if (srst) begin
                    dout_reg      <= DOUT_INITVAL;
                    dout_last_reg <= 1'b0;
                    valid_reg     <= 1'b0;
                end else begin
                    valid_reg <= rd_ok;
                    if (rd_ok)
                        {dout_last_reg, dout_reg} <= mem[rp_reg[ADDR_WIDTH-1:0]];
                end
            end

            assign dout      = dout_reg;
            assign dout_last = dout_last_reg;
            assign valid     = valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_udp_pkt_fifo.sv
// Drives a registered-read and a show-ahead instance with identical stimulus
// and checks both against a queue-based frame model.
module tb_udp_pkt_fifo;

    localparam int         AW    = 3;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] INITV = 8'hC3;

    logic       clk, srst, we, wlast, wdrop, re;
    logic [7:0] di;

    logic [7:0]  dout   [2];
    logic        dlast  [2];
    logic        valid  [2];
    logic        empty  [2];
    logic        aempty [2];
    logic        full   [2];
    logic        afull  [2];
    logic        wrs    [2];
    logic        ovf    [2];
    logic        udf    [2];
    logic        drp    [2];
    logic [AW:0] rdu    [2];
    logic [AW:0] wru    [2];
    logic [AW:0] pkt    [2];

    int n_checks = 0;
    int n_fail   = 0;

    udp_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .SHOW_AHEAD_EN(0),
                   .AL_FULL_NUM(3), .AL_EMPTY_NUM(2), .DOUT_INITVAL(INITV)) u_dut0 (
        .clk(clk), .srst(srst), .we(we), .di(di), .wlast(wlast), .wdrop(wdrop), .re(re),
        .dout(dout[0]), .dout_last(dlast[0]), .valid(valid[0]),
        .empty_flag(empty[0]), .aempty(aempty[0]), .full_flag(full[0]), .afull(afull[0]),
        .wr_success(wrs[0]), .overflow(ovf[0]), .underflow(udf[0]), .drop_done(drp[0]),
        .rdusedw(rdu[0]), .wrusedw(wru[0]), .pkt_cnt(pkt[0]));

    udp_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .SHOW_AHEAD_EN(1),
                   .AL_FULL_NUM(3), .AL_EMPTY_NUM(2), .DOUT_INITVAL(INITV)) u_dut1 (
        .clk(clk), .srst(srst), .we(we), .di(di), .wlast(wlast), .wdrop(wdrop), .re(re),
        .dout(dout[1]), .dout_last(dlast[1]), .valid(valid[1]),
        .empty_flag(empty[1]), .aempty(aempty[1]), .full_flag(full[1]), .afull(afull[1]),
        .wr_success(wrs[1]), .overflow(ovf[1]), .underflow(udf[1]), .drop_done(drp[1]),
        .rdusedw(rdu[1]), .wrusedw(wru[1]), .pkt_cnt(pkt[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: committed words, the frame being written, and its error state.
    logic [8:0] q[$];
    logic [8:0] pend[$];
    logic       m_err;
    logic [7:0] e_dout0;
    logic       e_last0, e_valid0;
    logic       e_succ, e_over, e_under, e_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        m_err    = 1'b0;
        e_dout0  = INITV;
        e_last0  = 1'b0;
        e_valid0 = 1'b0;
        e_succ   = 1'b0;
        e_over   = 1'b0;
        e_under  = 1'b0;
        e_drop   = 1'b0;
    endtask

    task automatic check_all();
        int nq, nw, np;
        logic [7:0] h_d;
        logic       h_l;
        nq = q.size();
        nw = q.size() + pend.size();
        np = 0;
        foreach (q[i]) if (q[i][8]) np++;
        h_d = (nq > 0) ? q[0][7:0] : INITV;
        h_l = (nq > 0) ? q[0][8] : 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rdusedw%0d", k), 32'(rdu[k]), 32'(nq));
            check($sformatf("wrusedw%0d", k), 32'(wru[k]), 32'(nw));
            check($sformatf("pkt_cnt%0d", k), 32'(pkt[k]), 32'(np));
            check($sformatf("empty%0d", k),   32'(empty[k]),  32'(nq == 0));
            check($sformatf("full%0d", k),    32'(full[k]),   32'(nw == DEPTH));
            check($sformatf("afull%0d", k),   32'(afull[k]),  32'(nw >= DEPTH - 3));
            check($sformatf("aempty%0d", k),  32'(aempty[k]), 32'(nq <= 2));
            check($sformatf("wr_success%0d", k), 32'(wrs[k]), 32'(e_succ));
            check($sformatf("overflow%0d", k),   32'(ovf[k]), 32'(e_over));
            check($sformatf("underflow%0d", k),  32'(udf[k]), 32'(e_under));
            check($sformatf("drop_done%0d", k),  32'(drp[k]), 32'(e_drop));
        end
        check("valid0",     32'(valid[0]), 32'(e_valid0));
        check("dout0",      32'(dout[0]),  32'(e_dout0));
        check("dout_last0", 32'(dlast[0]), 32'(e_last0));
        check("valid1",     32'(valid[1]), 32'(nq > 0));
        check("dout1",      32'(dout[1]),  32'(h_d));
        check("dout_last1", 32'(dlast[1]), 32'(h_l));
    endtask

    task automatic step(input logic w, input logic wl, input logic wd, input logic r,
                        input logic [7:0] d);
        logic       m_full, m_empty;
        logic [8:0] ent;
        we = w; wlast = wl; wdrop = wd; re = r; di = d;
        @(posedge clk);
        m_full   = (q.size() + pend.size()) == DEPTH;
        m_empty  = (q.size() == 0);
        e_under  = r && m_empty;
        e_over   = w && m_full && !wd;
        e_succ   = 1'b0;
        e_drop   = 1'b0;
        e_valid0 = 1'b0;
        if (r && !m_empty) begin
            ent      = q.pop_front();
            e_dout0  = ent[7:0];
            e_last0  = ent[8];
            e_valid0 = 1'b1;
        end
        if (wd) begin
            pend.delete();
            m_err  = 1'b0;
            e_drop = 1'b1;
        end else if (w) begin
            if (wl && (m_full || m_err)) begin
                pend.delete();
                m_err  = 1'b0;
                e_drop = 1'b1;
            end else if (m_full) begin
                m_err = 1'b1;
            end else begin
                pend.push_back({wl, d});
                if (wl) begin
                    foreach (pend[i]) q.push_back(pend[i]);
                    pend.delete();
                    e_succ = 1'b1;
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int flen, fpos;
        logic wl_r;
        srst = 1'b1; we = 1'b0; wlast = 1'b0; wdrop = 1'b0; re = 1'b0; di = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        srst = 1'b0;
        idle();

        // 5-word frame, rdusedw stays 0 until commit
        for (int i = 0; i < 5; i++) step(1'b1, i == 4, 1'b0, 1'b0, 8'h11 + 8'(i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();

        // Three words then discard; following read underflows
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h40 + 8'(i));
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h4F);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();

        // Fill completely with one open frame, then overflow on its last word
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h60 + 8'(i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h6F);
        idle();

        // Two-word frame, visible in show-ahead mode the cycle after commit
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();

        // Streaming 4-word frames with reads whenever data is committed
        for (int i = 0; i < 3 * DEPTH; i++)
            step(1'b1, (i % 4) == 3, 1'b0, q.size() > 0, 8'(i * 7 + 3));
        while (q.size() > 0) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle();

        // Random traffic with variable frame lengths, drops and a mid-run reset
        flen = 1; fpos = 0;
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                we = 1'b0; wlast = 1'b0; wdrop = 1'b0; re = 1'b0;
                #3 srst = 1'b1;
                model_reset();
                #1 check_all();
                @(posedge clk);
                #1 check_all();
                srst = 1'b0;
                fpos = 0;
            end
            if ($urandom_range(0, 3) != 0) begin
                wl_r = (fpos == flen - 1);
                step(1'b1, wl_r, $urandom_range(0, 31) == 0, $urandom_range(0, 2) != 0,
                     8'($urandom));
                fpos++;
                if (wl_r || wdrop) begin
                    fpos = 0;
                    flen = $urandom_range(1, 10);
                end
            end else begin
                step(1'b0, 1'b0, 1'b0, $urandom_range(0, 1) != 0, 8'($urandom));
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
